// File: rtl/minisys_md_pkg.sv
// minisys_md_pkg
//   Shared definitions for the Minisys multiply/divide unit: the 3-bit
//   operation encodings, the MDU state enum and a width-generic
//   two's-complement negate helper.
package minisys_md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   // Widest operand neg2c handles. Callers size-cast in and out; the low
   // bits of a wide negate equal the negate at any narrower width.
   localparam int unsigned MD_MAXW = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX
   } md_state_t;

   function automatic logic [MD_MAXW-1:0] neg2c(input logic [MD_MAXW-1:0] x);
      return ~x + MD_MAXW'(1);
   endfunction

endpackage

// File: rtl/minisys_div_core.sv
// minisys_div_core
//   Unsigned radix-2 restoring divider, one quotient bit per step.
//   Ports:
//     clk, clrn              clock, asynchronous active-low reset
//     i_load                 capture dividend/divisor, arm WIDTH steps
//     i_step                 perform one step (ignored once all are done)
//     i_dividend, i_divisor  unsigned operands
//     o_quot, o_rem          quotient / remainder (valid after WIDTH steps)
//     o_done                 high during the cycle of the final step
module minisys_div_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quot;   // dividend shifts out the top, quotient bits shift in
   logic [WIDTH-1:0] r_div;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   w_trial;

   // Top bit of the trial difference is the borrow: set means restore.
   assign w_trial = {r_rem, r_quot[WIDTH-1]} - {1'b0, r_div};

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_rem  <= '0;
         r_quot <= '0;
         r_div  <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_rem  <= '0;
         r_quot <= i_dividend;
         r_div  <= i_divisor;
         r_cnt  <= CW'(WIDTH);
      end else if (i_step && (r_cnt != '0)) begin
         r_cnt  <= r_cnt - CW'(1);
         r_quot <= {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
         r_rem  <= w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quot[WIDTH-1]}
                                  : w_trial[WIDTH-1:0];
      end
   end

   assign o_quot = r_quot;
   assign o_rem  = r_rem;
   assign o_done = i_step && (r_cnt == CW'(1));

endmodule

// File: rtl/minisys_mdu.sv
// minisys_mdu
//   Multiply/divide unit owning the architectural HI/LO registers.
//   Ports:
//     clk, clrn   clock, asynchronous active-low reset
//     start, op   request valid / operation (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//     a, b        rs / rt operands
//     flush       abort the in-flight operation (also drops a same-cycle start)
//     busy        multi-cycle operation in progress
//     over        one-cycle pulse after HI/LO are written by MULT/DIV
//     pause       start while busy (combinational stall request)
//     dz_err      one-cycle divide-by-zero pulse (trap mode only)
//     hi, lo      HI/LO registers
module minisys_mdu
   import minisys_md_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,   // even, 8..64
   parameter int unsigned MULT_LAT     = 4,
   parameter bit          DIVZERO_TRAP = 1'b0
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             over,
   output logic             pause,
   output logic             dz_err,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned MCW = $clog2(MULT_LAT + 1);

   md_state_t          r_state;
   logic [MCW-1:0]     r_cnt;
   logic [2*WIDTH-1:0] r_ma;
   logic [2*WIDTH-1:0] r_mb;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_a;       // dividend as supplied, for the divide-by-zero result
   logic               r_busy;
   logic               r_over;
   logic               r_dz_err;
   logic               r_qneg;
   logic               r_rneg;
   logic               r_dz;

   logic [2*WIDTH-1:0] w_prod;
   logic               w_sgn_div;
   logic               w_a_neg;
   logic               w_b_neg;
   logic               w_b_zero;
   logic               w_trap;
   logic               w_div_load;
   logic               w_div_step;
   logic               w_div_last;
   logic [WIDTH-1:0]   w_amag;
   logic [WIDTH-1:0]   w_bmag;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_quot_s;
   logic [WIDTH-1:0]   w_rem_s;

   // Operands are pre-extended to 2*WIDTH at issue, so the low 2*WIDTH bits
   // of a plain product are correct for both signed and unsigned multiply.
   assign w_prod = r_ma * r_mb;

   assign w_sgn_div = (op == MD_DIV);
   assign w_a_neg   = w_sgn_div && a[WIDTH-1];
   assign w_b_neg   = w_sgn_div && b[WIDTH-1];
   assign w_b_zero  = (b == '0);
   assign w_trap    = DIVZERO_TRAP && w_b_zero;
   assign w_amag    = w_a_neg ? WIDTH'(neg2c(MD_MAXW'(a))) : a;
   assign w_bmag    = w_b_neg ? WIDTH'(neg2c(MD_MAXW'(b))) : b;

   assign w_div_load = start && !flush && (r_state == ST_IDLE) &&
                       ((op == MD_DIV) || (op == MD_DIVU)) && !w_trap;
   assign w_div_step = (r_state == ST_DIV) && !flush;

   minisys_div_core #(.WIDTH(WIDTH)) u_div (
      .clk        (clk),
      .clrn       (clrn),
      .i_load     (w_div_load),
      .i_step     (w_div_step),
      .i_dividend (w_amag),
      .i_divisor  (w_bmag),
      .o_quot     (w_quot),
      .o_rem      (w_rem),
      .o_done     (w_div_last)
   );

   assign w_quot_s = r_qneg ? WIDTH'(neg2c(MD_MAXW'(w_quot))) : w_quot;
   assign w_rem_s  = r_rneg ? WIDTH'(neg2c(MD_MAXW'(w_rem)))  : w_rem;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_ma     <= '0;
         r_mb     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_a      <= '0;
         r_busy   <= 1'b0;
         r_over   <= 1'b0;
         r_dz_err <= 1'b0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_dz     <= 1'b0;
      end else begin
         r_over   <= 1'b0;
         r_dz_err <= 1'b0;
         if (flush) begin
            // Flush beats both a new start and a completing write.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     case (op)
                        MD_MULT, MD_MULTU: begin
                           r_ma    <= (op == MD_MULT) ? {{WIDTH{a[WIDTH-1]}}, a}
                                                      : {{WIDTH{1'b0}}, a};
                           r_mb    <= (op == MD_MULT) ? {{WIDTH{b[WIDTH-1]}}, b}
                                                      : {{WIDTH{1'b0}}, b};
                           r_cnt   <= MCW'(MULT_LAT);
                           r_state <= ST_MUL;
                           r_busy  <= 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                           if (w_trap) begin
                              r_over   <= 1'b1;
                              r_dz_err <= 1'b1;
                           end else begin
                              r_qneg  <= w_a_neg ^ w_b_neg;
                              r_rneg  <= w_a_neg;
                              r_dz    <= w_b_zero;
                              r_a     <= a;
                              r_state <= ST_DIV;
                              r_busy  <= 1'b1;
                           end
                        end
                        MD_MTHI: r_hi <= a;
                        MD_MTLO: r_lo <= a;
                        default: ;
                     endcase
                  end
               end
               ST_MUL: begin
                  if (r_cnt == MCW'(1)) begin
                     r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                     r_lo    <= w_prod[WIDTH-1:0];
                     r_over  <= 1'b1;
                     r_cnt   <= '0;
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt - MCW'(1);
                  end
               end
               ST_DIV: begin
                  if (w_div_last) r_state <= ST_FIX;
               end
               ST_FIX: begin
                  r_lo    <= r_dz ? '1  : w_quot_s;
                  r_hi    <= r_dz ? r_a : w_rem_s;
                  r_over  <= 1'b1;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy   = r_busy;
   assign over   = r_over;
   assign dz_err = r_dz_err;
   assign pause  = start && r_busy;
   assign hi     = r_hi;
   assign lo     = r_lo;

endmodule

// File: tb/tb_minisys_mdu.sv
// tb_minisys_mdu
//   Self-checking bench: a 32-bit MDU (MULT_LAT=4) checked through a result
//   scoreboard, plus a trap-mode instance and a 16-bit / MULT_LAT=1 instance.
module tb_minisys_mdu;
   import minisys_md_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clrn;
   // main instance
   logic        start, flush, busy, over, pause, dz_err;
   logic [2:0]  op;
   logic [31:0] a, b, hi, lo;
   // trap-mode instance
   logic        t_start, t_flush, t_busy, t_over, t_pause, t_dz_err;
   logic [2:0]  t_op;
   logic [31:0] t_a, t_b, t_hi, t_lo;
   // 16-bit instance
   logic        s_start, s_flush, s_busy, s_over, s_pause, s_dz_err;
   logic [2:0]  s_op;
   logic [15:0] s_a, s_b, s_hi, s_lo;

   minisys_mdu #(.WIDTH(32), .MULT_LAT(4), .DIVZERO_TRAP(1'b0)) u_dut (
      .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .busy(busy), .over(over), .pause(pause), .dz_err(dz_err), .hi(hi), .lo(lo));

   minisys_mdu #(.WIDTH(32), .MULT_LAT(4), .DIVZERO_TRAP(1'b1)) u_dut_trap (
      .clk(clk), .clrn(clrn), .start(t_start), .op(t_op), .a(t_a), .b(t_b), .flush(t_flush),
      .busy(t_busy), .over(t_over), .pause(t_pause), .dz_err(t_dz_err), .hi(t_hi), .lo(t_lo));

   minisys_mdu #(.WIDTH(16), .MULT_LAT(1), .DIVZERO_TRAP(1'b0)) u_dut16 (
      .clk(clk), .clrn(clrn), .start(s_start), .op(s_op), .a(s_a), .b(s_b), .flush(s_flush),
      .busy(s_busy), .over(s_over), .pause(s_pause), .dz_err(s_dz_err), .hi(s_hi), .lo(s_lo));

   int n_total = 0;
   int n_bad   = 0;

   logic [63:0] sb_q[$];
   logic [63:0] mon_e;
   logic [31:0] m_hi, m_lo;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference {hi,lo} for a 32-bit MULT/DIV operation.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
      longint      sx, sy, q, rm;
      logic [63:0] r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = '0;
      case (o)
         MD_MULT:  r = sx * sy;
         MD_MULTU: r = {32'd0, x} * {32'd0, y};
         MD_DIV: begin
            if (y == 0) r = {x, 32'hFFFF_FFFF};
            else begin
               q  = sx / sy;
               rm = sx % sy;
               r  = {rm[31:0], q[31:0]};
            end
         end
         MD_DIVU: begin
            if (y == 0) r = {x, 32'hFFFF_FFFF};
            else        r = {x % y, x / y};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Main-instance monitor: every over pulse must match the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (over) begin
         if (sb_q.size() == 0) chk("over_unexpected", over, 0);
         else begin
            mon_e = sb_q.pop_front();
            chk("sb_hi", hi, mon_e[63:32]);
            chk("sb_lo", lo, mon_e[31:0]);
            chk("sb_dz_err", dz_err, 0);
            m_hi = mon_e[63:32];
            m_lo = mon_e[31:0];
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit push);
      @(posedge clk); #1;
      start = 1'b1; op = o; a = x; b = y;
      if (push) sb_q.push_back(model(o, x, y));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int exp_busy, input string tag);
      int nb;
      bit seen;
      issue(o, x, y, 1'b1);
      nb = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (over) seen = 1'b1;
         else begin
            if (busy) nb++;
            @(posedge clk); #1;
         end
      end
      chk({tag, "_over"}, seen, 1);
      chk({tag, "_busy_cycles"}, nb, exp_busy);
      @(posedge clk); #1;
      chk({tag, "_over_single"}, over, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int          nb;
      bit          seen;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      clrn = 1'b0;
      start = 0; flush = 0; op = 0; a = 0; b = 0;
      t_start = 0; t_flush = 0; t_op = 0; t_a = 0; t_b = 0;
      s_start = 0; s_flush = 0; s_op = 0; s_a = 0; s_b = 0;
      m_hi = 0; m_lo = 0;
      #12;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_over", over, 0);
      chk("rst_dz_err", dz_err, 0);
      #11 clrn = 1'b1;

      run_op(MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 4,  "mult");
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 4,  "multu");
      run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 33, "div");
      run_op(MD_DIVU,  32'h0000_0064, 32'h0000_0000, 33, "divu_dz");
      run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, "div_mneg");
      run_op(MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 33, "div_pn");
      run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 33, "div_dzneg");
      for (int k = 0; k < 6; k++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = (k % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
         run_op(ro, ra, rb, (ro < 2) ? 4 : 33, "rand");
      end

      // MTHI while busy is paused and ignored; retried afterwards it lands.
      issue(MD_DIVU, 32'd100, 32'd7, 1'b1);
      start = 1'b1; op = MD_MTHI; a = 32'h0000_000A;
      for (int i = 0; i < 3; i++) begin
         chk("mthi_pause", pause, 1);
         @(posedge clk); #1;
         chk("mthi_hi_held", hi, m_hi);
      end
      start = 1'b0;
      for (int i = 0; i < 60 && !over; i++) begin
         @(posedge clk); #1;
      end
      chk("mthi_div_over", over, 1);
      issue(MD_MTHI, 32'h0000_000A, 32'd0, 1'b0);
      chk("mthi_retry_hi", hi, 32'h0000_000A);
      chk("mthi_no_busy", busy, 0);
      chk("mthi_no_over", over, 0);
      m_hi = 32'h0000_000A;
      issue(MD_MTLO, 32'h0000_00B5, 32'd0, 1'b0);
      chk("mtlo_lo", lo, 32'h0000_00B5);
      m_lo = 32'h0000_00B5;
      start = 1'b1; op = 3'd7;
      chk("idle_pause", pause, 0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("nop_busy", busy, 0);
      chk("nop_hi", hi, m_hi);

      // Flush at busy cycle 10 of a divide.
      issue(MD_DIV, 32'd1234, 32'd5, 1'b0);
      repeat (9) begin
         @(posedge clk); #1;
      end
      chk("fl_busy10", busy, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fl_busy_off", busy, 0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (over) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("fl_no_over", seen, 0);
      chk("fl_hi", hi, m_hi);
      chk("fl_lo", lo, m_lo);

      // Flush with start in IDLE drops the start.
      start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd3; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flst_busy", busy, 0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (over) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("flst_no_over", seen, 0);

      // Flush on the completing edge of a multiply.
      issue(MD_MULT, 32'd3, 32'd3, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("flc_busy_last", busy, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flc_busy", busy, 0);
      chk("flc_over", over, 0);
      chk("flc_hi", hi, m_hi);
      chk("flc_lo", lo, m_lo);

      // Asynchronous reset mid-multiply.
      issue(MD_MULT, 32'd5, 32'd6, 1'b0);
      @(posedge clk); #1;
      clrn = 1'b0;
      #1;
      chk("rstmid_hi", hi, 0);
      chk("rstmid_lo", lo, 0);
      chk("rstmid_busy", busy, 0);
      m_hi = 0; m_lo = 0;
      #3 clrn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (over || busy) seen = 1'b1;
      end
      chk("rstmid_idle", seen, 0);

      // Trap mode: divide by zero pulses dz_err/over in N+1, HI/LO kept.
      @(posedge clk); #1;
      t_start = 1'b1; t_op = MD_MTHI; t_a = 32'h0000_1234;
      @(posedge clk); #1;
      t_op = MD_MTLO; t_a = 32'h0000_5678;
      @(posedge clk); #1;
      t_start = 1'b0;
      chk("trap_pre_hi", t_hi, 32'h0000_1234);
      chk("trap_pre_lo", t_lo, 32'h0000_5678);
      t_start = 1'b1; t_op = MD_DIVU; t_a = 32'h0000_0064; t_b = 32'd0;
      @(posedge clk); #1;
      t_start = 1'b0;
      chk("trap_dz_err", t_dz_err, 1);
      chk("trap_over", t_over, 1);
      chk("trap_busy", t_busy, 0);
      chk("trap_hi", t_hi, 32'h0000_1234);
      chk("trap_lo", t_lo, 32'h0000_5678);
      @(posedge clk); #1;
      chk("trap_dz_err_off", t_dz_err, 0);
      chk("trap_over_off", t_over, 0);
      chk("trap_busy_off", t_busy, 0);
      t_start = 1'b1; t_op = MD_DIVU; t_a = 32'd100; t_b = 32'd7;
      @(posedge clk); #1;
      t_start = 1'b0;
      nb = 0; seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (t_over) seen = 1'b1;
         else begin
            if (t_busy) nb++;
            @(posedge clk); #1;
         end
      end
      chk("trap_div_busy", nb, 33);
      chk("trap_div_lo", t_lo, 32'd14);
      chk("trap_div_hi", t_hi, 32'd2);
      chk("trap_div_dz_err", t_dz_err, 0);

      // 16-bit, single-cycle multiply latency.
      s_start = 1'b1; s_op = MD_MULT; s_a = 16'h8000; s_b = 16'h8000;
      @(posedge clk); #1;
      s_start = 1'b0;
      chk("w16_mul_busy", s_busy, 1);
      @(posedge clk); #1;
      chk("w16_mul_over", s_over, 1);
      chk("w16_mul_hi", s_hi, 16'h4000);
      chk("w16_mul_lo", s_lo, 16'h0000);
      @(posedge clk); #1;
      chk("w16_mul_over_off", s_over, 0);
      s_start = 1'b1; s_op = MD_DIV; s_a = 16'hFFF9; s_b = 16'h0002;
      @(posedge clk); #1;
      s_start = 1'b0;
      nb = 0; seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (s_over) seen = 1'b1;
         else begin
            if (s_busy) nb++;
            @(posedge clk); #1;
         end
      end
      chk("w16_div_busy", nb, 17);
      chk("w16_div_lo", s_lo, 16'hFFFD);
      chk("w16_div_hi", s_hi, 16'hFFFF);

      chk("sb_drain", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
